// File: rtl/ram_fifo_ctrl.sv
// FIFO controller that wraps the single-port RAM_16x4: one RAM access per cycle, push/pop arbitration, post-reset clear.
// Optional sticky overflow/underflow flags are built when FIFO_ERR_EN is defined.
//
// state  | meaning
// S_INIT | ram_reset held high, traffic blocked for INIT_CYCLES edges
// S_RUN  | normal push/pop arbitration
`timescale 1ns/1ps
module ram_fifo_ctrl #(
   parameter int WIDTH       = 4,
   parameter int ADDR_W      = 4,
   parameter int INIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic [WIDTH-1:0]  push_data,
   output logic              push_ready,
   input  logic              pop,
   output logic              pop_ready,
   output logic [WIDTH-1:0]  pop_data,
   output logic              pop_valid,
   output logic [ADDR_W:0]   count,
   output logic              full,
   output logic              empty,
   output logic              ram_reset,
   output logic              ram_set,
   output logic              ram_write_enable,
   output logic              ram_read_enable,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [WIDTH-1:0]  ram_data_in,
   input  logic [WIDTH-1:0]  ram_data_out
`ifdef FIFO_ERR_EN
   ,
   output logic              err_overflow,
   output logic              err_underflow
`endif
);

   localparam int DEPTH  = 2 ** ADDR_W;
   localparam int INIT_W = $clog2(INIT_CYCLES + 1);
   localparam logic PRI_PUSH = 1'b0;
   localparam logic PRI_POP  = 1'b1;

   typedef enum logic {S_INIT, S_RUN} state_t;

   state_t              state, state_nxt;
   logic [INIT_W-1:0]   init_cnt;
   logic [ADDR_W-1:0]   wr_ptr, rd_ptr;
   logic                pri;
   logic                run, can_push, can_pop, push_req, pop_req;
   logic                grant_push, grant_pop;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_INIT;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_INIT:  if (init_cnt == INIT_W'(INIT_CYCLES - 1)) state_nxt = S_RUN;
         S_RUN:   state_nxt = S_RUN;
         default: state_nxt = S_INIT;
      endcase
   end

   always_comb begin
      run        = (state == S_RUN);
      can_push   = !full;
      can_pop    = !empty;
      push_req   = push && can_push;
      pop_req    = pop && can_pop;
      push_ready = run && can_push && !(pop_req && pri == PRI_POP);
      pop_ready  = run && can_pop && !(push_req && pri == PRI_PUSH);
      grant_push = push && push_ready;
      grant_pop  = pop && pop_ready;
      ram_reset        = !run;
      ram_set          = 1'b0;
      ram_write_enable = grant_push;
      ram_read_enable  = grant_pop;
      ram_addr         = '0;
      ram_data_in      = '0;
      if (grant_push) begin
         ram_addr    = wr_ptr;
         ram_data_in = push_data;
      end else if (grant_pop) begin
         ram_addr = rd_ptr;
      end
   end

   assign full     = (count == (ADDR_W+1)'(DEPTH));
   assign empty    = (count == '0);
   assign pop_data = ram_data_out;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         init_cnt  <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         pri       <= PRI_PUSH;
         pop_valid <= 1'b0;
      end else begin
         if (state == S_INIT) init_cnt <= init_cnt + INIT_W'(1);
         if (grant_push) begin
            wr_ptr <= wr_ptr + ADDR_W'(1);
            count  <= count + (ADDR_W+1)'(1);
         end else if (grant_pop) begin
            rd_ptr <= rd_ptr + ADDR_W'(1);
            count  <= count - (ADDR_W+1)'(1);
         end
         // pri only flips when both sides were actually eligible
         if (run && push_req && pop_req) pri <= ~pri;
         pop_valid <= grant_pop;
      end
   end

`ifdef FIFO_ERR_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err_overflow  <= 1'b0;
         err_underflow <= 1'b0;
      end else begin
         if (run && push && full) err_overflow  <= 1'b1;
         if (run && pop && empty) err_underflow <= 1'b1;
      end
   end
`endif

endmodule

// File: doc/ram_fifo_ctrl.md
Name: ram_fifo_ctrl

Overview:
- Upstream controller that turns the single-port RAM_16x4 into a 16-deep, 4-bit FIFO.
- Producers see a push handshake and consumers see a pop handshake. The block generates every RAM control/address/data signal.
- Arbitrates one RAM access per cycle, keeps read/write pointers and occupancy, and sequences a RAM clear after reset.

Parameters:
- WIDTH, 4: data word width; must match RAM data width.
- ADDR_W, 4: RAM address width; depth = 2**ADDR_W = 16.
- INIT_CYCLES, 2: cycles ram_reset is held after reset release before accepting traffic (≥1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- push  in  1  producer request.
- push_data  in  WIDTH  word to enqueue.
- push_ready  out  1  push accepted this cycle when push & push_ready.
- pop  in  1  consumer request.
- pop_ready  out  1  pop accepted this cycle when pop & pop_ready.
- pop_data  out  WIDTH  dequeued word; equals ram_data_out.
- pop_valid  out  1  pop_data valid this cycle.
- count  out  ADDR_W+1  occupancy, 0..16.
- full  out  1  count == 16.
- empty  out  1  count == 0.
- ram_reset  out  1  active-high clear to RAM.
- ram_set  out  1  RAM set; tied 0.
- ram_write_enable  out  1  RAM write strobe.
- ram_read_enable  out  1  RAM read strobe.
- ram_addr  out  ADDR_W  RAM address.
- ram_data_in  out  WIDTH  RAM write data.
- ram_data_out  in  WIDTH  RAM read data.

Behaviour:
- RAM contract:
  - Write commits at the rising edge where ram_write_enable=1.
  - Read registers the addressed word at the rising edge where ram_read_enable=1; ram_data_out is valid the following cycle.
  - Never both strobes in one cycle.
- Reset (reset=0, asynchronous):
  - State=INIT, init counter=0, wr_ptr=rd_ptr=0, count=0, pri=PUSH.
  - pop_valid=0, ram_reset=1, push_ready=pop_ready=0, both RAM strobes 0, ram_addr=0, ram_data_in=0.
  - empty=1, full=0, ram_set=0.
- FSM INIT:
  - ram_reset=1 and both readys 0 for INIT_CYCLES rising edges after reset release.
  - Then RUN with ram_reset=0.
- FSM RUN, grant logic (combinational):
  - can_push = !full, can_pop = !empty.
  - If push&can_push and pop&can_pop: grant the side named by pri, then toggle pri at the edge.
  - Otherwise grant the single eligible request; pri is unchanged.
  - push_ready = RUN & can_push & !(pop & can_pop & pri==POP).
  - pop_ready = RUN & can_pop & !(push & can_push & pri==PUSH).
- Push grant:
  - ram_write_enable=1, ram_addr=wr_ptr, ram_data_in=push_data.
  - At the edge: wr_ptr+1 (wraps 15→0), count+1.
- Pop grant:
  - ram_read_enable=1, ram_addr=rd_ptr.
  - At the edge: rd_ptr+1 (wraps 15→0), count-1, pop_valid<=1.
  - pop_valid is a one-cycle pulse per accepted pop (latency 1).
  - pop_data passes ram_data_out through.
- No grant: strobes 0, ram_addr=0, ram_data_in=0, pop_valid<=0.
- Boundaries:
  - Push while full: push_ready=0, no write, no state change.
  - Pop while empty: pop_ready=0, no read, no state change.
  - Full with both requesting: pop only; pri unchanged.
  - Empty with both requesting: push only; pri unchanged.
- Reset mid-operation: all state returns to reset values immediately. An in-flight pop_valid is dropped. FIFO contents are discarded because ram_reset clears the RAM.

Optional Feature:
- Macro: FIFO_ERR_EN.
- Defined:
  - Adds outputs err_overflow and err_underflow (1 bit each, reset 0), both sticky and cleared only by reset.
  - err_overflow sets on a RUN cycle with push=1 & full=1.
  - err_underflow sets on a RUN cycle with pop=1 & empty=1.
- Undefined: both ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset/init: hold reset=0 for 3 cycles, then release.
  - During reset and the first 2 cycles after release: ram_reset=1, push_ready=0.
  - Third cycle: ram_reset=0, push_ready=1, empty=1, count=0.
- Write: push 1010, 0101, 1111, 0001 on consecutive cycles.
  - ram_write_enable pulses with ram_addr 0,1,2,3 and matching ram_data_in.
  - count=4.
- Read: pop 4 times.
  - ram_read_enable with ram_addr 0..3.
  - pop_valid the next cycle each time, with pop_data 1010, 0101, 1111, 0001.
  - Ends with empty=1.
- Full: push 16 words, then a 17th.
  - full=1, count=16.
  - 17th push: push_ready=0, no ram_write_enable.
  - With FIFO_ERR_EN: err_overflow=1 and it stays set.
- Contention: count=3, push=pop=1 held 4 cycles from pri=PUSH.
  - Grants are push, pop, push, pop; count ends at 3; never two strobes in one cycle.
- Wrap/reset: 20 interleaved push/pop pairs.
  - ram_addr wraps 15→0 and data order is preserved.
  - Assert reset mid-stream: count=0, pop_valid=0, ram_reset=1 immediately.
